// File: rtl/wb_scheduler.sv
// Write-back scheduler: arbitrates the single register-file write port between the ALU
// and memory return paths, tracks outstanding long-latency writes, and stalls issue.
// Optional scoreboard consistency checking is enabled with `define WB_SCHED_CHECK_EN.
module wb_scheduler #(
   parameter int NREG     = 32,
   parameter int DW       = 32,
   parameter int MAX_OUT  = 4,
   parameter int MAX_WAIT = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          issue_valid,
   input  logic [4:0]    issue_rs1,
   input  logic [4:0]    issue_rs2,
   input  logic [4:0]    issue_rd,
   input  logic          issue_long,
   output logic          stall,
   input  logic          alu_valid,
   input  logic [4:0]    alu_rd,
   input  logic [DW-1:0] alu_data,
   input  logic          mem_valid,
   input  logic [4:0]    mem_rd,
   input  logic [DW-1:0] mem_data,
   output logic          mem_ready,
   output logic          WB,
   output logic [4:0]    Rd,
   output logic [DW-1:0] reg_s
`ifdef WB_SCHED_CHECK_EN
   ,
   output logic          sb_err
`endif
);

   localparam int OW = $clog2(MAX_OUT + 1);
   localparam int WW = $clog2(MAX_WAIT + 1);
   localparam logic [OW-1:0] OUT_FULL = OW'(MAX_OUT);
   localparam logic [OW-1:0] OUT_ONE  = OW'(1);
   localparam logic [WW-1:0] WAIT_SAT = WW'(MAX_WAIT);
   localparam logic [WW-1:0] WAIT_ONE = WW'(1);

   logic [NREG-1:0] pending_q, pending_d;
   logic [OW-1:0]   out_cnt_q, out_cnt_d;
   logic [WW-1:0]   wait_cnt_q, wait_cnt_d;
   logic            wb_q, wb_d;
   logic [4:0]      rd_q, rd_d;
   logic [DW-1:0]   data_q, data_d;
   logic            set_en, clr_en;

   // Hazard detection and memory-path grant are combinational so issue reacts this cycle.
   always_comb begin
      mem_ready = mem_valid && !alu_valid;
      stall     = issue_valid &&
                  (pending_q[issue_rs1] || pending_q[issue_rs2] || pending_q[issue_rd] ||
                   (issue_long && (out_cnt_q == OUT_FULL)) ||
                   (wait_cnt_q == WAIT_SAT));
   end

   // Register 0 is never tracked; a clear only counts if the bit was actually set.
   always_comb begin
      set_en    = issue_valid && !stall && issue_long && (issue_rd != 5'd0);
      clr_en    = mem_ready && pending_q[mem_rd];
      pending_d = pending_q;
      if (clr_en) pending_d[mem_rd] = 1'b0;
      if (set_en) pending_d[issue_rd] = 1'b1;
      out_cnt_d = out_cnt_q;
      case ({set_en, clr_en})
         2'b10:   out_cnt_d = out_cnt_q + OUT_ONE;
         2'b01:   out_cnt_d = out_cnt_q - OUT_ONE;
         default: out_cnt_d = out_cnt_q;
      endcase
   end

   always_comb begin
      wait_cnt_d = '0;
      if (mem_valid && !mem_ready)
         wait_cnt_d = (wait_cnt_q == WAIT_SAT) ? wait_cnt_q : wait_cnt_q + WAIT_ONE;
   end

   // ALU has absolute priority; when nobody writes, address and data hold.
   always_comb begin
      wb_d   = alu_valid || mem_ready;
      rd_d   = rd_q;
      data_d = data_q;
      if (alu_valid) begin
         rd_d   = alu_rd;
         data_d = alu_data;
      end else if (mem_ready) begin
         rd_d   = mem_rd;
         data_d = mem_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q  <= '0;
         out_cnt_q  <= '0;
         wait_cnt_q <= '0;
         wb_q       <= 1'b0;
         rd_q       <= '0;
         data_q     <= '0;
      end else begin
         pending_q  <= pending_d;
         out_cnt_q  <= out_cnt_d;
         wait_cnt_q <= wait_cnt_d;
         wb_q       <= wb_d;
         rd_q       <= rd_d;
         data_q     <= data_d;
      end
   end

   assign WB    = wb_q;
   assign Rd    = rd_q;
   assign reg_s = data_q;

`ifdef WB_SCHED_CHECK_EN
   logic sb_err_q, sb_err_d;

   // Sticky: a return with no matching outstanding write, or a set into a full scoreboard.
   always_comb begin
      sb_err_d = sb_err_q;
      if (mem_ready && !pending_q[mem_rd]) sb_err_d = 1'b1;
      if (set_en && (out_cnt_q == OUT_FULL)) sb_err_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sb_err_q <= 1'b0;
      else        sb_err_q <= sb_err_d;
   end

   assign sb_err = sb_err_q;
`endif

endmodule

// File: tb/tb_wb_scheduler.sv
// Directed self-checking bench for wb_scheduler with default parameters
// (MAX_OUT=4, MAX_WAIT=3).
module tb_wb_scheduler;

   logic        clk;
   logic        rst_n;
   logic        issue_valid;
   logic [4:0]  issue_rs1, issue_rs2, issue_rd;
   logic        issue_long;
   logic        stall;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        mem_valid;
   logic [4:0]  mem_rd;
   logic [31:0] mem_data;
   logic        mem_ready;
   logic        WB;
   logic [4:0]  Rd;
   logic [31:0] reg_s;
`ifdef WB_SCHED_CHECK_EN
   logic        sb_err;
`endif

   int n_checks = 0;
   int n_errors = 0;

   wb_scheduler dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .issue_valid (issue_valid),
      .issue_rs1   (issue_rs1),
      .issue_rs2   (issue_rs2),
      .issue_rd    (issue_rd),
      .issue_long  (issue_long),
      .stall       (stall),
      .alu_valid   (alu_valid),
      .alu_rd      (alu_rd),
      .alu_data    (alu_data),
      .mem_valid   (mem_valid),
      .mem_rd      (mem_rd),
      .mem_data    (mem_data),
      .mem_ready   (mem_ready),
      .WB          (WB),
      .Rd          (Rd),
      .reg_s       (reg_s)
`ifdef WB_SCHED_CHECK_EN
      ,
      .sb_err      (sb_err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic idle();
      issue_valid = 1'b0; issue_rs1 = '0; issue_rs2 = '0; issue_rd = '0; issue_long = 1'b0;
      alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
      mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
   endtask

   // Advance to just after the next rising edge; inputs are changed here.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic lng);
      issue_valid = 1'b1; issue_rs1 = rs1; issue_rs2 = rs2; issue_rd = rd; issue_long = lng;
   endtask

   task automatic mem(input logic [4:0] rd, input logic [31:0] data);
      mem_valid = 1'b1; mem_rd = rd; mem_data = data;
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      repeat (2) @(posedge clk);
      #1;
      check("rst_wb", WB, 0);
      check("rst_rd", Rd, 0);
      check("rst_reg_s", reg_s, 0);
      check("rst_stall", stall, 0);
      check("rst_mem_ready", mem_ready, 0);
      rst_n = 1'b1;
      tick();
      check("idle_wb", WB, 0);
      check("idle_stall", stall, 0);

      // RAW on a long-latency destination
      issue(5'd0, 5'd0, 5'd5, 1'b1);
      #1 check("raw_first_issue", stall, 0);
      tick();
      issue(5'd5, 5'd0, 5'd6, 1'b0);
      #1 check("raw_stall_c1", stall, 1);
      tick();
      mem(5'd5, 32'hDEADBEEF);
      #1 check("raw_stall_c2", stall, 1);
      check("raw_mem_ready", mem_ready, 1);
      tick();
      mem_valid = 1'b0;
      #1 check("raw_wb", WB, 1);
      check("raw_rd", Rd, 5);
      check("raw_reg_s", reg_s, 32'hDEADBEEF);
      check("raw_released", stall, 0);
      tick();
      idle();

      // ALU beats memory, memory follows
      alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h11;
      mem(5'd7, 32'h77);
      #1 check("arb_mem_blocked", mem_ready, 0);
      tick();
      alu_valid = 1'b0;
      #1 check("arb_alu_rd", Rd, 3);
      check("arb_alu_data", reg_s, 32'h11);
      check("arb_mem_granted", mem_ready, 1);
      tick();
      mem_valid = 1'b0;
      #1 check("arb_mem_rd", Rd, 7);
      check("arb_mem_data", reg_s, 32'h77);
      tick();
      #1 check("arb_wb_idle", WB, 0);
      check("arb_rd_hold", Rd, 7);
      check("arb_data_hold", reg_s, 32'h77);

      // Starvation: ALU keeps winning while memory waits
      issue(5'd0, 5'd0, 5'd8, 1'b0);
      alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
      mem(5'd10, 32'hA0);
      #1 check("starve_c1", stall, 0);
      tick();
      #1 check("starve_c2", stall, 0);
      tick();
      #1 check("starve_c3", stall, 0);
      tick();
      #1 check("starve_c4", stall, 1);
      tick();
      alu_valid = 1'b0;
      #1 check("starve_sat_stall", stall, 1);
      check("starve_grant", mem_ready, 1);
      tick();
      mem_valid = 1'b0;
      #1 check("starve_cleared", stall, 0);
      check("starve_rd", Rd, 10);
      check("starve_data", reg_s, 32'hA0);
      tick();
      idle();

      // Fill the scoreboard
      for (int r = 1; r <= 4; r++) begin
         issue(5'd0, 5'd0, 5'(r), 1'b1);
         #1 check($sformatf("fill_rd%0d", r), stall, 0);
         tick();
      end
      issue(5'd0, 5'd0, 5'd11, 1'b1);
      #1 check("full_long_stall", stall, 1);
      issue(5'd13, 5'd0, 5'd12, 1'b0);
      #1 check("full_short_ok", stall, 0);
      issue(5'd0, 5'd0, 5'd11, 1'b1);
      mem(5'd2, 32'h22);
      #1 check("full_still", stall, 1);
      check("full_ret_ready", mem_ready, 1);
      tick();
      mem_valid = 1'b0;
      #1 check("full_slot_freed", stall, 0);
      tick();
      idle();
      issue(5'd4, 5'd0, 5'd14, 1'b0);
      #1 check("pend4_raw", stall, 1);
      issue(5'd0, 5'd11, 5'd14, 1'b0);
      #1 check("pend11_raw", stall, 1);
      idle();

      // Drain to two pending (4, 11) with a write in flight, then reset mid-cycle
      mem(5'd1, 32'h101);
      tick();
      mem(5'd3, 32'h303);
      tick();
      idle();
      #1 check("pre_rst_wb", WB, 1);
      check("pre_rst_rd", Rd, 3);
      issue(5'd4, 5'd11, 5'd15, 1'b0);
      #1 check("pre_rst_stall", stall, 1);
      rst_n = 1'b0;
      #1 check("async_wb", WB, 0);
      check("async_rd", Rd, 0);
      check("async_reg_s", reg_s, 0);
      check("async_stall", stall, 0);
      tick();
      rst_n = 1'b1;
      tick();
      #1 check("post_rst_issue", stall, 0);
      tick();
      idle();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/wb_scheduler.md
Name: wb_scheduler

Overview:
- Owns the single register-file write port and shares it between two requesters: the single-cycle ALU result path and the long-latency memory/load return path.
- Keeps a scoreboard of destination registers with long-latency writes outstanding.
- Drives the issue-stage stall for RAW/WAW hazards on those registers, and for memory-path starvation.
- Sits between the execute/memory stages and the register file; drives its WB, Rd and reg_s inputs.

Parameters:
- NREG, 32, number of architectural registers; register 0 is hard-wired zero.
- DW, 32, data width of write-back values.
- MAX_OUT, 4, maximum outstanding long-latency writes (1..NREG-1).
- MAX_WAIT, 3, cycles the memory path may be refused before the issue stage is stalled (>=1).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- issue_valid  in  1  instruction attempting to issue this cycle.
- issue_rs1  in  5  source register 1.
- issue_rs2  in  5  source register 2.
- issue_rd  in  5  destination register.
- issue_long  in  1  destination is written by the memory path.
- stall  out  1  issue blocked this cycle (combinational).
- alu_valid  in  1  ALU result present; cannot be back-pressured.
- alu_rd  in  5  ALU destination register.
- alu_data  in  DW  ALU result.
- mem_valid  in  1  memory result present; held stable until accepted.
- mem_rd  in  5  memory destination register.
- mem_data  in  DW  memory result.
- mem_ready  out  1  memory result accepted this cycle (combinational).
- WB  out  1  register-file write enable (registered).
- Rd  out  5  register-file destination (registered).
- reg_s  out  DW  register-file write data (registered).

Behaviour:
- Reset (async, rst_n=0): WB=0, Rd=0, reg_s=0, all pending bits 0, out_cnt=0, wait_cnt=0. Takes effect immediately, including mid-operation.
- Write arbitration, priority order:
  - ALU always wins: if alu_valid, the write is ALU and mem_ready=0.
  - Else mem_ready=mem_valid, and the write is memory.
- Write latency: one cycle. The winner's rd/data appear on Rd/reg_s with WB=1 on the next edge; otherwise WB=0, and Rd/reg_s hold their last values.
- Register 0:
  - Writes with rd=0 still drive WB=1, Rd=0; the register file ignores them.
  - Register 0 is never marked pending.
- Scoreboard:
  - One pending bit per register.
  - out_cnt counts the set bits (0..MAX_OUT).
- Issue accepted = issue_valid && !stall.
  - If accepted, issue_long=1 and issue_rd!=0: set pending[issue_rd], out_cnt+1.
- Memory write accepted (mem_valid && mem_ready): clear pending[mem_rd], out_cnt-1, provided the bit was set.
- Set and clear in the same cycle on different registers: out_cnt unchanged.
- Same-register set and clear cannot occur: WAW hazards are stalled.
- stall=1 when issue_valid and any of the following holds:
  - pending[issue_rs1] (RAW hazard).
  - pending[issue_rs2] (RAW hazard).
  - pending[issue_rd] (WAW hazard).
  - issue_long && out_cnt==MAX_OUT (scoreboard full).
  - wait_cnt==MAX_WAIT (starvation).
- Starvation counter (wait_cnt):
  - Increments, saturating at MAX_WAIT, each cycle mem_valid && !mem_ready.
  - Clears on a memory accept, or when mem_valid=0.
  - At MAX_WAIT it stalls issue until the ALU path drains and the memory write is granted.
- Memory write to a register whose pending bit is clear: the write still proceeds; the scoreboard is unchanged.

Optional Feature:
- Macro: WB_SCHED_CHECK_EN.
- Defined:
  - Adds output sb_err (1 bit, reset 0), sticky until reset.
  - sb_err is set on a memory accept whose mem_rd pending bit is clear.
  - sb_err is also set on an issue that would overflow out_cnt.
- Undefined: port absent; no checking logic.

Test Plan:
- Reset then idle, all inputs 0 -> WB=0, Rd=0, reg_s=0, stall=0, mem_ready=0.
- Issue rd=5 long, then next cycle issue rs1=5 -> second issue stall=1 until mem_valid rd=5 data=0xDEADBEEF accepted. The cycle after: WB=1, Rd=5, reg_s=0xDEADBEEF, stall=0.
- alu_valid rd=3 data=0x11 and mem_valid rd=7 in the same cycle -> mem_ready=0, next-cycle Rd=3. Then, with alu idle, mem_ready=1, following cycle Rd=7.
- alu_valid held high 3 cycles with mem_valid high, MAX_WAIT=3 -> stall asserts on the 4th cycle. Dropping alu_valid grants the memory write and clears stall.
- Four long issues rd=1..4 (MAX_OUT=4) -> fifth long issue stalled, non-long issue with clear sources accepted. One memory return frees a slot.
- Assert rst_n=0 with 2 pending and WB=1 -> outputs 0 immediately. After release, a previously pending rs issues with stall=0.
